// File: rtl/seq_mult_pkg.sv
// Shared types and step tables for the sequential half-width multiplier.
// The step tables are used by seq_mult_core (optional feature: SEQ_MULT_SKIP_ZERO_EN).
package seq_mult_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STEP0 = 3'd1,
    STEP1 = 3'd2,
    STEP2 = 3'd3,
    STEP3 = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [2:0] CNT_IDLE = 3'b000;
  localparam logic [2:0] CNT_DONE = 3'b100;

  // Per-step left shift of the partial product: 0, HALF, HALF, N.
  typedef enum logic [1:0] {
    SH_ZERO = 2'd0,
    SH_HALF = 2'd1,
    SH_FULL = 2'd2
  } shift_sel_t;

  typedef struct packed {
    logic a_hi;
    logic b_hi;
  } half_sel_t;

  function automatic shift_sel_t step_shift(input state_t st);
    shift_sel_t sh;
    case (st)
      STEP0:   sh = SH_ZERO;
      STEP1:   sh = SH_HALF;
      STEP2:   sh = SH_HALF;
      STEP3:   sh = SH_FULL;
      default: sh = SH_ZERO;
    endcase
    return sh;
  endfunction

  function automatic half_sel_t step_half_sel(input state_t st);
    half_sel_t sel;
    case (st)
      STEP0:   sel = '{a_hi: 1'b0, b_hi: 1'b0};
      STEP1:   sel = '{a_hi: 1'b1, b_hi: 1'b0};
      STEP2:   sel = '{a_hi: 1'b0, b_hi: 1'b1};
      STEP3:   sel = '{a_hi: 1'b1, b_hi: 1'b1};
      default: sel = '{a_hi: 1'b0, b_hi: 1'b0};
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/seq_mult_core_mult_half.sv
// Combinational HALF x HALF unsigned multiplier producing a 2*HALF-bit result.
module mult_half #(
  parameter int HALF = 4
) (
  input  logic [HALF-1:0]   a,
  input  logic [HALF-1:0]   b,
  output logic [2*HALF-1:0] p
);

  // Operands are zero-extended so the multiply is evaluated at full width.
  always_comb begin
    p = {{HALF{1'b0}}, a} * {{HALF{1'b0}}, b};
  end

endmodule

// File: rtl/seq_mult_core.sv
// Sequential N x N unsigned multiplier: four half-width partial products accumulated over four steps.
// Optional feature macro: SEQ_MULT_SKIP_ZERO_EN (a zero operand finishes after STEP0 with product 0).
module seq_mult_core
  import seq_mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset_a,
  input  logic           start,
  input  logic [N-1:0]   dataa,
  input  logic [N-1:0]   datab,
  output logic [2*N-1:0] product_out,
  output logic           done_flag,
  output logic           busy,
  output logic [2:0]     state_count
);

  localparam int HALF = N / 2;

  state_t          state_r;
  logic [N-1:0]    a_r;
  logic [N-1:0]    b_r;
  logic [2*N-1:0]  acc_r;

  half_sel_t       sel_s;
  logic [HALF-1:0] a_half_s;
  logic [HALF-1:0] b_half_s;
  logic [N-1:0]    pp_s;
  logic [31:0]     shamt_s;
  logic [2*N-1:0]  shifted_s;
  logic [2*N-1:0]  sum_s;
  logic            start_accept_s;
  logic            skip_s;

  mult_half #(
    .HALF (HALF)
  ) u_mult_half (
    .a (a_half_s),
    .b (b_half_s),
    .p (pp_s)
  );

  // Operand half selection, partial-product alignment and accumulate adder.
  always_comb begin
    sel_s          = step_half_sel(state_r);
    a_half_s       = sel_s.a_hi ? a_r[N-1:HALF] : a_r[HALF-1:0];
    b_half_s       = sel_s.b_hi ? b_r[N-1:HALF] : b_r[HALF-1:0];
    case (step_shift(state_r))
      SH_ZERO: shamt_s = 32'd0;
      SH_HALF: shamt_s = 32'(HALF);
      SH_FULL: shamt_s = 32'(N);
      default: shamt_s = 32'd0;
    endcase
    shifted_s      = {{N{1'b0}}, pp_s} << shamt_s;
    sum_s          = acc_r + shifted_s;
    start_accept_s = start && ((state_r == IDLE) || (state_r == DONE));
  end

`ifdef SEQ_MULT_SKIP_ZERO_EN
  logic zero_r;

  // Remembers whether either operand was zero at the accepted start edge.
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      zero_r <= 1'b0;
    end else if (start_accept_s) begin
      zero_r <= (dataa == {N{1'b0}}) || (datab == {N{1'b0}});
    end else begin
      zero_r <= zero_r;
    end
  end

  assign skip_s = zero_r;
`else
  assign skip_s = 1'b0;
`endif

  // Controller and datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      state_r     <= IDLE;
      a_r         <= {N{1'b0}};
      b_r         <= {N{1'b0}};
      acc_r       <= {(2*N){1'b0}};
      product_out <= {(2*N){1'b0}};
      done_flag   <= 1'b0;
      busy        <= 1'b0;
      state_count <= CNT_IDLE;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start_accept_s) begin
            a_r         <= dataa;
            b_r         <= datab;
            acc_r       <= {(2*N){1'b0}};
            state_r     <= STEP0;
            state_count <= 3'd0;
            done_flag   <= 1'b0;
            busy        <= 1'b1;
          end
        end
        STEP0: begin
          if (skip_s) begin
            state_r     <= DONE;
            product_out <= {(2*N){1'b0}};
            done_flag   <= 1'b1;
            busy        <= 1'b0;
            state_count <= CNT_DONE;
          end else begin
            acc_r       <= sum_s;
            state_r     <= STEP1;
            state_count <= 3'd1;
          end
        end
        STEP1: begin
          acc_r       <= sum_s;
          state_r     <= STEP2;
          state_count <= 3'd2;
        end
        STEP2: begin
          acc_r       <= sum_s;
          state_r     <= STEP3;
          state_count <= 3'd3;
        end
        STEP3: begin
          acc_r       <= sum_s;
          product_out <= sum_s;
          state_r     <= DONE;
          done_flag   <= 1'b1;
          busy        <= 1'b0;
          state_count <= CNT_DONE;
        end
        default: begin
          state_r     <= IDLE;
          acc_r       <= {(2*N){1'b0}};
          done_flag   <= 1'b0;
          busy        <= 1'b0;
          state_count <= CNT_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_core.sv
// Randomized self-checking bench for seq_mult_core against a cycles-since-capture reference model.
module tb_seq_mult_core;

`ifdef SEQ_MULT_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk;
  logic        reset_a;
  logic        start;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic [15:0] product_out;
  logic        done_flag;
  logic        busy;
  logic [2:0]  state_count;

  int n_checks = 0;
  int n_errors = 0;

  seq_mult_core #(.N(8)) dut (
    .clk         (clk),
    .reset_a     (reset_a),
    .start       (start),
    .dataa       (dataa),
    .datab       (datab),
    .product_out (product_out),
    .done_flag   (done_flag),
    .busy        (busy),
    .state_count (state_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a job is the exact product plus how many clocks it takes
  // (4, or 1 for a zero operand when skipping is enabled); outputs follow from
  // the number of clocks elapsed since the capture edge.
  int          m_elapsed;  // -1 when no job has ever been started
  int          m_len;
  logic [15:0] m_pend;
  logic [15:0] m_prod;
  bit          m_done;

  always @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      m_elapsed = -1;
      m_len     = 4;
      m_pend    = 16'd0;
      m_prod    = 16'd0;
      m_done    = 1'b0;
    end else begin
      if ((m_elapsed < 0 || m_done) && start) begin
        m_pend    = 16'(dataa) * 16'(datab);
        m_len     = (SKIP && (dataa == 8'd0 || datab == 8'd0)) ? 1 : 4;
        m_elapsed = 0;
        m_done    = 1'b0;
      end else if (m_elapsed >= 0 && !m_done) begin
        m_elapsed = m_elapsed + 1;
        if (m_elapsed == m_len) begin
          m_prod = m_pend;
          m_done = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (!reset_a) begin
      check("product_out", 32'(product_out), 32'(m_prod));
      check("done_flag", 32'(done_flag), 32'(m_done));
      check("busy", 32'(busy), 32'(m_elapsed >= 0 && !m_done));
      check("state_count", 32'(state_count),
            m_done ? 32'd4 : (m_elapsed < 0 ? 32'd0 : 32'(m_elapsed)));
    end
  end

  // Issues one multiply, waits (bounded) for done and pins the result and latency.
  task automatic do_mult(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_p, input int exp_lat, input string name);
    int lat;
    @(negedge clk);
    dataa = a; datab = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dataa = 8'($urandom); datab = 8'($urandom);
    lat = 1;
    while (!done_flag && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_done"}, 32'(done_flag), 32'd1);
    check({name, "_product"}, 32'(product_out), 32'(exp_p));
    check({name, "_latency"}, 32'(lat - 1), 32'(exp_lat));
    check({name, "_count"}, 32'(state_count), 32'd4);
  endtask

  initial begin
    reset_a = 1'b1; start = 1'b0; dataa = 8'd0; datab = 8'd0;
    #13;
    check("reset_product", 32'(product_out), 32'd0);
    check("reset_count", 32'(state_count), 32'd0);
    @(negedge clk);
    reset_a = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_done", 32'(done_flag), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    do_mult(8'hFF, 8'hFF, 16'hFE01, 4, "max");
    do_mult(8'd25, 8'd13, 16'd325, 4, "mixed1");
    do_mult(8'hA5, 8'h3C, 16'h26AC, 4, "mixed2");

    // start re-asserted during STEP1 must be ignored
    @(negedge clk);
    dataa = 8'd7; datab = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("ignore_in_step1", 32'(state_count), 32'd1);
    dataa = 8'd2; datab = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("ignore_done", 32'(done_flag), 32'd1);
    check("ignore_product", 32'(product_out), 32'd63);

    // asynchronous reset while in STEP2
    @(negedge clk);
    dataa = 8'hC3; datab = 8'h5A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_count", 32'(state_count), 32'd2);
    #2 reset_a = 1'b1;
    #1;
    check("async_product", 32'(product_out), 32'd0);
    check("async_done", 32'(done_flag), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_count", 32'(state_count), 32'd0);
    #1 reset_a = 1'b0;
    do_mult(8'd3, 8'd4, 16'd12, 4, "post_reset");

    do_mult(8'd0, 8'h80, 16'd0, SKIP ? 1 : 4, "zero_a");
    do_mult(8'h55, 8'd0, 16'd0, SKIP ? 1 : 4, "zero_b");

    // start held high: back-to-back restarts from DONE
    @(negedge clk);
    start = 1'b1;
    repeat (30) begin
      dataa = 8'($urandom); datab = 8'($urandom);
      @(negedge clk);
    end
    start = 1'b0;

    // random traffic with occasional zero operands and spurious starts
    repeat (400) begin
      dataa = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      datab = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      start = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_core.md
Name: seq_mult_core

Overview:
Sequential 8x8 unsigned multiplier datapath and controller built around one HALF x HALF partial-product multiplier.
- Computes one partial product per cycle over four cycles and accumulates the shifted results into a 2N-bit product.
- Exports a 3-bit step counter, state_count, which drives the seven-segment encoder directly downstream.
- The display shows 0..3 during compute and "E" (End) once the product is valid.

Parameters:
N, 8, operand width; must be even and ≥4
HALF, N/2, partial-product operand width (derived, not overridable)

Ports:
clk  in  1  system clock, rising edge
reset_a  in  1  asynchronous active-high reset
start  in  1  sampled high in IDLE or DONE begins a new multiply
dataa  in  N  multiplicand, unsigned; sampled only on the start edge
datab  in  N  multiplier, unsigned; sampled only on the start edge
product_out  out  2N  final product; valid while done_flag=1
done_flag  out  1  high in DONE
busy  out  1  high in STEP0..STEP3
state_count  out  3  step index to seven-segment encoder

Behaviour:
- Reset (asynchronous, any time, including mid-operation) forces:
  - state=IDLE, acc=0, product_out=0, done_flag=0, busy=0, state_count=3'b000.
  - Captured operands are cleared to 0.
- States: IDLE, STEP0, STEP1, STEP2, STEP3, DONE. One transition per clock; no wait states.
- IDLE/DONE with start=1 at edge E0:
  - Capture a_r=dataa and b_r=datab.
  - acc←0; state←STEP0; state_count←0; done_flag←0; busy←1.
  - product_out keeps its old value until E4.
- STEPk with k=0..3: the edge at the end of STEPk adds the partial product to acc and advances state.
  - STEP0: a_lo*b_lo, shifted left 0.
  - STEP1: a_hi*b_lo, shifted left HALF.
  - STEP2: a_lo*b_hi, shifted left HALF.
  - STEP3: a_hi*b_hi, shifted left N.
  - state_count equals k while in STEPk.
- Edge E4 (end of STEP3):
  - state←DONE; product_out←acc+pp3<<N; done_flag←1; busy←0; state_count←3'b100.
- Latency: start edge to done_flag high is 4 clocks after the capture edge.
- DONE holds product_out, done_flag and state_count until the next accepted start or reset.
- start during STEP0..STEP3 is ignored. Operands are not re-sampled and the sequence is not restarted.
- start held high continuously: each return to DONE immediately restarts on the next edge. done_flag is high for exactly one cycle per result in that case.
- Accumulator arithmetic:
  - acc is 2N bits and all additions are unsigned.
  - The maximum product (2^N-1)^2 fits in 2N bits, so no overflow is possible and no carry-out is kept.
- dataa/datab changes outside the start edge have no effect.
- state_count encodings: 000..011 = compute steps; 100 = done/End; IDLE = 000.
  - 101..111 are never driven.

Optional Feature:
Macro SEQ_MULT_SKIP_ZERO_EN.
- Defined: if dataa==0 or datab==0 on the accepted start edge, the next edge goes STEP0→DONE directly.
  - product_out←0; done_flag←1; state_count←3'b100.
  - Latency is 1 clock instead of 4.
  - busy is high for that single STEP0 cycle.
- Not defined: zero operands take the full 4-step sequence and produce 0 at E4.

Decomposition:
- Package seq_mult_pkg holds:
  - the state enum (IDLE, STEP0..STEP3, DONE);
  - constants CNT_IDLE=3'b000 and CNT_DONE=3'b100;
  - per-step shift amounts (0, HALF, HALF, N);
  - the half-operand select table (lo/hi for a and b per step).
- One sub-module: mult_half, a combinational HALF x HALF → N-bit unsigned multiplier.
  - Fed by the operand select muxes.
  - Output goes to a shifter and the accumulator adder in seq_mult_core.

Test Plan:
- Reset then idle: reset_a pulse, no start → product_out=0, done_flag=0, busy=0, state_count=000 for 10 cycles.
- Basic multiply: dataa=8'hFF, datab=8'hFF, start 1 cycle → state_count 0,1,2,3 on consecutive cycles; 4 clocks after capture, product_out=16'hFE01, done_flag=1, state_count=100.
- Mixed values: dataa=8'd25, datab=8'd13 → product_out=16'd325. Then dataa=8'hA5, datab=8'h3C → 16'h26AC. done_flag drops on the second start edge.
- start ignored mid-op: start pulse with 8'd7 x 8'd9, then start=1 again with 8'd2 x 8'd2 during STEP1 → result 16'd63 at E4; no restart.
- Reset mid-operation: assert reset_a asynchronously during STEP2 → all outputs 0 immediately (before the next clock edge); a new start with 8'd3 x 8'd4 → 16'd12.
- Zero operand: dataa=0, datab=8'h80 → with SEQ_MULT_SKIP_ZERO_EN, done_flag 1 clock after capture and product_out=0; without it, done_flag after 4 clocks and product_out=0.
